// File: rtl/motion_alarm_seq.sv
// Alarm event sequencer: runs one beep/blink pattern, a frame-capture handshake and a PS
// interrupt for each latched motion event, then clears the flag stage and holds off.
module motion_alarm_seq #(
  parameter int unsigned BEEP_HALF   = 25_000_000,
  parameter int unsigned BEEP_COUNT  = 4,
  parameter int unsigned CAP_TIMEOUT = 50_000_000,
  parameter int unsigned HOLDOFF     = 100_000_000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_motion_flag,
  input  logic             i_ps_ack,
  input  logic             i_cap_ack,
  output logic             o_buzzer,
  output logic             o_led,
  output logic             o_cap_req,
  output logic             o_irq,
  output logic             o_clr_flag,
  output logic             o_busy,
  output logic             o_cap_err,
  output logic [CNT_W-1:0] o_event_count
);

  localparam int unsigned NHALF  = 2 * BEEP_COUNT;
  localparam int unsigned HALF_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam int unsigned NH_W   = $clog2(NHALF + 1);
  localparam int unsigned CAP_W  = (CAP_TIMEOUT > 1) ? $clog2(CAP_TIMEOUT) : 1;
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ALARM    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_t;

  state_t             r_state;
  logic [HALF_W-1:0]  r_half_cnt;
  logic [NH_W-1:0]    r_half_idx;
  logic               r_beep_done;
  logic [CAP_W-1:0]   r_cap_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_buzzer;
  logic               r_led;
  logic               r_cap_req;
  logic               r_irq;
  logic               r_clr_flag;
  logic               r_busy;
  logic               r_cap_err;
  logic [CNT_W-1:0]   r_event_count;

  logic w_half_wrap;
  logic w_last_half;
  logic w_beep_done_nxt;
  logic w_cap_expire;
  logic w_cap_done_nxt;
  logic w_trigger;
  logic w_hold_end;
  logic w_cnt_max;

  assign w_half_wrap     = (r_half_cnt == HALF_W'(BEEP_HALF - 1));
  assign w_last_half     = (r_half_idx == NH_W'(NHALF - 1));
  assign w_beep_done_nxt = r_beep_done | (w_half_wrap & w_last_half);
  // an ack on the expiry edge wins over the timeout
  assign w_cap_expire    = r_cap_req & ~i_cap_ack & (r_cap_cnt == CAP_W'(CAP_TIMEOUT - 1));
  assign w_cap_done_nxt  = ~r_cap_req | i_cap_ack | w_cap_expire;
  assign w_trigger       = i_enable & i_motion_flag;
  assign w_hold_end      = (r_hold_cnt == HOLD_W'(HOLDOFF - 1));
  assign w_cnt_max       = &r_event_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_half_cnt    <= '0;
      r_half_idx    <= '0;
      r_beep_done   <= 1'b0;
      r_cap_cnt     <= '0;
      r_hold_cnt    <= '0;
      r_buzzer      <= 1'b0;
      r_led         <= 1'b0;
      r_cap_req     <= 1'b0;
      r_irq         <= 1'b0;
      r_clr_flag    <= 1'b0;
      r_busy        <= 1'b0;
      r_cap_err     <= 1'b0;
      r_event_count <= '0;
    end else begin
      r_clr_flag <= 1'b0;
      if ((r_state != S_IDLE) && !i_enable) begin
        // disarm: drop everything, release the flag stage, keep cap_err
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_buzzer   <= 1'b0;
        r_led      <= 1'b0;
        r_cap_req  <= 1'b0;
        r_irq      <= 1'b0;
        r_clr_flag <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_trigger) begin
              r_state     <= S_ALARM;
              r_busy      <= 1'b1;
              r_buzzer    <= 1'b1;
              r_led       <= 1'b1;
              r_cap_req   <= 1'b1;
              r_half_cnt  <= '0;
              r_half_idx  <= '0;
              r_beep_done <= 1'b0;
              r_cap_cnt   <= '0;
              if (!w_cnt_max) begin
                r_event_count <= r_event_count + CNT_W'(1);
              end
            end
          end
          S_ALARM: begin
            if (!r_beep_done) begin
              if (w_half_wrap) begin
                r_half_cnt <= '0;
                r_half_idx <= r_half_idx + NH_W'(1);
                if (w_last_half) begin
                  r_beep_done <= 1'b1;
                  r_buzzer    <= 1'b0;
                  r_led       <= 1'b0;
                end else begin
                  r_buzzer <= ~r_buzzer;
                  r_led    <= ~r_buzzer;
                end
              end else begin
                r_half_cnt <= r_half_cnt + HALF_W'(1);
              end
            end
            if (r_cap_req) begin
              if (i_cap_ack) begin
                r_cap_req <= 1'b0;
              end else if (w_cap_expire) begin
                r_cap_req <= 1'b0;
                r_cap_err <= 1'b1;
              end else begin
                r_cap_cnt <= r_cap_cnt + CAP_W'(1);
              end
            end
            // leave on the edge where both the beep and the capture finish
            if (w_beep_done_nxt && w_cap_done_nxt) begin
              r_state  <= S_WAIT_ACK;
              r_irq    <= 1'b1;
              r_led    <= 1'b1;
              r_buzzer <= 1'b0;
            end
          end
          S_WAIT_ACK: begin
            if (i_ps_ack) begin
              r_state    <= S_HOLDOFF;
              r_irq      <= 1'b0;
              r_led      <= 1'b0;
              r_clr_flag <= 1'b1;
              r_cap_err  <= 1'b0;
              r_hold_cnt <= '0;
            end
          end
          S_HOLDOFF: begin
            if (w_hold_end) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_buzzer      = r_buzzer;
  assign o_led         = r_led;
  assign o_cap_req     = r_cap_req;
  assign o_irq         = r_irq;
  assign o_clr_flag    = r_clr_flag;
  assign o_busy        = r_busy;
  assign o_cap_err     = r_cap_err;
  assign o_event_count = r_event_count;

endmodule

// File: tb/tb_motion_alarm_seq.sv
// Directed bench for motion_alarm_seq: timeline model compared every cycle against a
// 16-bit-counter instance and a 2-bit-counter instance, plus literal spot checks.
module tb_motion_alarm_seq;

  localparam int BH  = 4;
  localparam int BC  = 2;
  localparam int CT  = 20;
  localparam int HO  = 10;
  localparam int LEN = 2 * BH * BC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, mot = 1'b0, pack = 1'b0, cack = 1'b0;

  logic        d_buz, d_led, d_req, d_irq, d_clr, d_busy, d_err;
  logic [15:0] d_cnt;
  logic        s_buz, s_led, s_req, s_irq, s_clr, s_busy, s_err;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  motion_alarm_seq #(.BEEP_HALF(BH), .BEEP_COUNT(BC), .CAP_TIMEOUT(CT), .HOLDOFF(HO), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_motion_flag(mot), .i_ps_ack(pack), .i_cap_ack(cack),
    .o_buzzer(d_buz), .o_led(d_led), .o_cap_req(d_req), .o_irq(d_irq), .o_clr_flag(d_clr),
    .o_busy(d_busy), .o_cap_err(d_err), .o_event_count(d_cnt));

  motion_alarm_seq #(.BEEP_HALF(BH), .BEEP_COUNT(BC), .CAP_TIMEOUT(CT), .HOLDOFF(HO), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_motion_flag(mot), .i_ps_ack(pack), .i_cap_ack(cack),
    .o_buzzer(s_buz), .o_led(s_led), .o_cap_req(s_req), .o_irq(s_irq), .o_clr_flag(s_clr),
    .o_busy(s_busy), .o_cap_err(s_err), .o_event_count(s_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: each event is described by its trigger edge and elapsed edges since.
  int m_mode = 0;   // 0 idle, 1 alarm, 2 waiting for PS, 3 cooldown
  int m_cyc = 0, m_t0 = 0, m_th = 0, m_cnt = 0;
  bit m_cap_open = 0, m_err = 0, m_clr = 0;
  bit m_buz = 0, m_led = 0, m_req = 0, m_irq = 0;

  always @(posedge clk or posedge rst) begin
    int k;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_cap_open = 0; m_err = 0; m_clr = 0;
    end else begin
      m_cyc++;
      m_clr = 0;
      if (m_mode != 0 && !en) begin
        m_mode = 0; m_clr = 1;
      end else if (m_mode == 0) begin
        if (en && mot) begin
          m_mode = 1; m_t0 = m_cyc; m_cnt++; m_cap_open = 1;
        end
      end else if (m_mode == 1) begin
        k = m_cyc - m_t0;
        if (m_cap_open) begin
          if (cack) m_cap_open = 0;
          else if (k >= CT) begin m_cap_open = 0; m_err = 1; end
        end
        if (k >= LEN && !m_cap_open) m_mode = 2;
      end else if (m_mode == 2) begin
        if (pack) begin m_mode = 3; m_th = m_cyc; m_err = 0; m_clr = 1; end
      end else begin
        if (m_cyc - m_th >= HO) m_mode = 0;
      end
    end
    k = m_cyc - m_t0;
    m_buz = (m_mode == 1) && (k < LEN) && ((k / BH) % 2 == 0);
    m_led = m_buz || (m_mode == 2);
    m_req = (m_mode == 1) && m_cap_open;
    m_irq = (m_mode == 2);
  end

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    chk("buzzer", 32'(d_buz), 32'(m_buz));
    chk("led", 32'(d_led), 32'(m_led));
    chk("cap_req", 32'(d_req), 32'(m_req));
    chk("irq", 32'(d_irq), 32'(m_irq));
    chk("clr_flag", 32'(d_clr), 32'(m_clr));
    chk("busy", 32'(d_busy), 32'(m_mode != 0));
    chk("cap_err", 32'(d_err), 32'(m_err));
    chk("event_count", 32'(d_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    chk("sat_outputs", 32'({s_buz, s_led, s_req, s_irq, s_clr, s_busy, s_err}),
        32'({m_buz, m_led, m_req, m_irq, m_clr, m_mode != 0, m_err}));
    chk("sat_count", 32'(s_cnt), 32'((m_cnt > 3) ? 3 : m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    logic [15:0] bz;
    logic [15:0] pat;
    pat = 16'hF0F0;

    run(3);
    chk("rst_outputs", 32'({d_buz, d_led, d_req, d_irq, d_clr, d_busy, d_err}), 32'd0);
    chk("rst_count", 32'(d_cnt), 32'd0);
    rst = 1'b0;
    run(2);
    en = 1'b1;
    run(2);

    // basic event
    mot = 1'b1;
    tick();
    chk("trig_buzzer", 32'(d_buz), 32'd1);
    chk("trig_cap_req", 32'(d_req), 32'd1);
    chk("trig_count", 32'(d_cnt), 32'd1);
    bz[15] = d_buz;
    for (int i = 1; i < 16; i++) begin
      if (i == 5) cack = 1'b1;
      tick();
      cack = 1'b0;
      bz[15-i] = d_buz;
      if (i == 4) chk("cap_req_before_ack", 32'(d_req), 32'd1);
      if (i == 5) chk("cap_req_at_ack", 32'(d_req), 32'd0);
    end
    for (int i = 0; i < 16; i++) chk("beep_pattern", 32'(bz[15-i]), 32'(pat[15-i]));
    chk("irq_before", 32'(d_irq), 32'd0);
    tick();
    chk("irq_rise", 32'(d_irq), 32'd1);
    run(3);
    pack = 1'b1;
    tick();
    pack = 1'b0;
    mot = 1'b0;
    chk("clr_at_ack", 32'(d_clr), 32'd1);
    chk("irq_after_ack", 32'(d_irq), 32'd0);
    tick();
    chk("clr_one_cycle", 32'(d_clr), 32'd0);
    run(8);
    chk("busy_in_holdoff", 32'(d_busy), 32'd1);
    tick();
    chk("busy_end", 32'(d_busy), 32'd0);

    // holdoff with motion held, then retrigger
    mot = 1'b1;
    tick();
    run(2);
    cack = 1'b1;
    tick();
    cack = 1'b0;
    run(13);
    chk("ho_irq", 32'(d_irq), 32'd1);
    pack = 1'b1;
    tick();
    pack = 1'b0;
    chk("ho_clr", 32'(d_clr), 32'd1);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("ho_no_retrigger", 32'(d_busy), 32'd1);
    end
    chk("ho_count", 32'(d_cnt), 32'd2);
    tick();
    chk("ho_idle", 32'(d_busy), 32'd0);
    tick();
    chk("retrigger_busy", 32'(d_busy), 32'd1);
    chk("retrigger_count", 32'(d_cnt), 32'd3);

    // capture timeout on this event
    run(19);
    chk("to_req_held", 32'(d_req), 32'd1);
    chk("to_irq_before", 32'(d_irq), 32'd0);
    tick();
    chk("to_req_drop", 32'(d_req), 32'd0);
    chk("to_err", 32'(d_err), 32'd1);
    chk("to_irq", 32'(d_irq), 32'd1);
    pack = 1'b1;
    tick();
    pack = 1'b0;
    mot = 1'b0;
    chk("to_err_cleared", 32'(d_err), 32'd0);
    run(11);
    chk("to_idle", 32'(d_busy), 32'd0);

    // abort mid-beep
    mot = 1'b1;
    tick();
    chk("ab_count", 32'(d_cnt), 32'd4);
    run(2);
    en = 1'b0;
    tick();
    mot = 1'b0;
    chk("ab_outputs", 32'({d_buz, d_led, d_req, d_irq, d_busy}), 32'd0);
    chk("ab_clr", 32'(d_clr), 32'd1);
    chk("ab_count_held", 32'(d_cnt), 32'd4);
    tick();
    chk("ab_clr_once", 32'(d_clr), 32'd0);
    en = 1'b1;

    // fifth event: stray acks, then ps_ack together with disarm
    mot = 1'b1;
    tick();
    chk("ev5_count", 32'(d_cnt), 32'd5);
    chk("sat_count_lit", 32'(s_cnt), 32'd3);
    tick();
    pack = 1'b1;
    tick();
    pack = 1'b0;
    cack = 1'b1;
    tick();
    cack = 1'b0;
    run(13);
    chk("ev5_irq", 32'(d_irq), 32'd1);
    cack = 1'b1;
    tick();
    cack = 1'b0;
    en = 1'b0;
    pack = 1'b1;
    tick();
    pack = 1'b0;
    mot = 1'b0;
    chk("sim_clr", 32'(d_clr), 32'd1);
    chk("sim_idle", 32'(d_busy), 32'd0);
    tick();
    chk("sim_clr_once", 32'(d_clr), 32'd0);
    en = 1'b1;

    // async reset while waiting for the PS
    mot = 1'b1;
    tick();
    cack = 1'b1;
    tick();
    cack = 1'b0;
    run(15);
    chk("rs_irq_before", 32'(d_irq), 32'd1);
    #4;
    rst = 1'b1;
    #1;
    chk("rs_irq", 32'(d_irq), 32'd0);
    chk("rs_led", 32'(d_led), 32'd0);
    chk("rs_clr", 32'(d_clr), 32'd0);
    chk("rs_count", 32'(d_cnt), 32'd0);
    mot = 1'b0;
    run(2);
    rst = 1'b0;
    run(3);
    chk("post_rst_clr", 32'(d_clr), 32'd0);
    chk("post_rst_busy", 32'(d_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
